rst_sequencer: RTL
==================

# rst_sequencer

Reset release sequencer for the on-chip domains fed by the reset synchronizer. It takes the already-synchronized system reset and holds every downstream block reset asserted for a minimum pulse. It then releases the block resets one at a time, in fixed index order, with a programmable gap, and reports completion. A one-cycle soft-reset request from the system controller re-runs the whole sequence without touching the global reset.

## Interface
- NUM_OUT, 3: number of sequenced block resets (≥1)
- PULSE_MIN, 8: cycles all block resets stay asserted before the first release (≥1)
- GAP_CYCLES, 4: cycles between consecutive releases (≥1)
- CNT_W, 4: counter width; must hold max(PULSE_MIN, GAP_CYCLES)

- CLK  input  1  block clock
- RST  input  1  synchronous, active-low reset; sampled on rising CLK only
- Soft_Rst_Req  input  1  soft-reset request, sampled each cycle, active high
- Hold  input  1  freezes the release gap counter while high (RELEASE state only)
- Soft_Rst_Ack  output  1  one-cycle pulse: soft request accepted
- Clk_En  output  1  clock-gate enable for the sequenced domains
- Rst_Out  output  NUM_OUT  active-low block resets; bit 0 released first
- Rst_Done  output  1  high when all Rst_Out bits are released

## Operation
- All outputs registered. On RST=0 at an edge: state=ASSERT, cnt=0, idx=0, Rst_Out=0, Clk_En=0, Rst_Done=0, Soft_Rst_Ack=0.
- ASSERT:
  - Clk_En←1 on the first edge with RST=1. Downstream blocks then see clocks with reset held.
  - At each edge: if cnt==PULSE_MIN, set Rst_Out[0]←1, idx←1, cnt←0, and go to RELEASE. Go to RUN instead if NUM_OUT==1, with Rst_Done←1. Otherwise cnt←cnt+1.
  - Soft_Rst_Req is ignored in ASSERT: no ack.
- RELEASE:
  - If Hold=1, cnt holds.
  - Else if cnt==GAP_CYCLES-1, set Rst_Out[idx]←1, cnt←0, idx←idx+1. If idx was NUM_OUT-1, set Rst_Done←1 and go to RUN.
  - Else cnt←cnt+1.
- RUN: outputs stable. Hold is ignored.
- Soft reset is accepted in RELEASE or RUN when Soft_Rst_Req=1 at an edge:
  - Rst_Out←0, Rst_Done←0, Soft_Rst_Ack←1, cnt←0, idx←0, state→ASSERT. Clk_En stays 1.
  - Soft_Rst_Req has priority over Hold and over a release due on the same edge; the release does not happen.
- Soft_Rst_Ack is high for exactly one cycle per accepted request. A request held high re-triggers only after the sequence re-enters RELEASE.
- Rst_Out bits only ever transition 0→1 in index order. All bits return to 0 together.
- Unused states decode to ASSERT with all block resets asserted.

## Timing
- Edge numbering: edge 1 is the first rising edge with RST=1.
- Power-up (defaults): Clk_En=1 after edge 1. Rst_Out[0] rises at edge PULSE_MIN+1=9, Rst_Out[1] at 13, Rst_Out[2] at 17, Rst_Done at 17.
- General rule: Rst_Out[k] rises at edge PULSE_MIN+1+k·GAP_CYCLES. Each sampled Hold=1 cycle in RELEASE adds one cycle to every later release.
- Soft reset accepted at edge e: Rst_Out=0 and Ack=1 after edge e, Ack=0 after edge e+1, Rst_Out[0] rises at edge e+PULSE_MIN+1. Later bits follow the same gap rule.
- RST=0 at any edge, mid-sequence included, takes effect at that edge and overrides Soft_Rst_Req and Hold. Clk_En drops with it.

## Test plan
- Power-up, defaults, Hold=0, no requests -> Rst_Out=000 through edge 8; 001 at 9; 011 at 13; 111 and Rst_Done=1 at 17. Clk_En=1 from edge 1.
- Hold=1 for edges 10–12 -> Rst_Out[1] at 16, Rst_Out[2] and Done at 20.
- Soft_Rst_Req pulse at edge 30 in RUN -> Rst_Out=000, Done=0, one-cycle Ack after edge 30. Rst_Out 001/011/111 at edges 39/43/47. Clk_En stays 1.
- Soft_Rst_Req at edge 13, the edge where Rst_Out[1] is due -> bit 1 is not released, Rst_Out=000, Ack pulse, restart with Rst_Out[0] at edge 22. Request at edge 5 (ASSERT) -> ignored, no Ack.
- RST=0 at edge 14 mid-release -> Rst_Out=000 and Clk_En=0 after edge 14. A fresh sequence runs from the next RST=1 edge.
- NUM_OUT=1, PULSE_MIN=1 -> Rst_Out[0] and Rst_Done rise together at edge 2.

Source files
------------

// File: rtl/rst_sequencer.sv
// Reset release sequencer: holds all block resets for a minimum pulse, then
// releases them one at a time in index order, with optional soft-reset re-run.
module rst_sequencer #(
  parameter int NUM_OUT    = 3,
  parameter int PULSE_MIN  = 8,
  parameter int GAP_CYCLES = 4,
  parameter int CNT_W      = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               Soft_Rst_Req,
  input  logic               Hold,
  output logic               Soft_Rst_Ack,
  output logic               Clk_En,
  output logic [NUM_OUT-1:0] Rst_Out,
  output logic               Rst_Done
);

  localparam int IDX_W = $clog2(NUM_OUT + 1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic [NUM_OUT-1:0] r_rst_out;
  logic               r_clk_en;
  logic               r_done;
  logic               r_ack;

  state_t             w_state_next;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [IDX_W-1:0]   w_idx_next;
  logic [NUM_OUT-1:0] w_rst_out_next;
  logic               w_clk_en_next;
  logic               w_done_next;
  logic               w_ack_next;
  logic [NUM_OUT-1:0] w_released;
  logic               w_soft_take;

  // Bits are released strictly in order, so the next pattern is a shift-in of a 1.
  assign w_released  = (r_rst_out << 1) | NUM_OUT'(1);
  assign w_soft_take = Soft_Rst_Req && ((r_state == ST_RELEASE) || (r_state == ST_RUN));

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state   <= ST_ASSERT;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_rst_out <= '0;
      r_clk_en  <= 1'b0;
      r_done    <= 1'b0;
      r_ack     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_idx     <= w_idx_next;
      r_rst_out <= w_rst_out_next;
      r_clk_en  <= w_clk_en_next;
      r_done    <= w_done_next;
      r_ack     <= w_ack_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_idx_next     = r_idx;
    w_rst_out_next = r_rst_out;
    w_clk_en_next  = r_clk_en;
    w_done_next    = r_done;
    w_ack_next     = 1'b0;

    // A soft request preempts both Hold and any release due on this edge.
    if (w_soft_take) begin
      w_state_next   = ST_ASSERT;
      w_cnt_next     = '0;
      w_idx_next     = '0;
      w_rst_out_next = '0;
      w_done_next    = 1'b0;
      w_ack_next     = 1'b1;
    end else begin
      case (r_state)
        ST_ASSERT: begin
          w_clk_en_next = 1'b1;
          if (r_cnt == CNT_W'(PULSE_MIN)) begin
            w_rst_out_next = w_released;
            w_idx_next     = IDX_W'(1);
            w_cnt_next     = '0;
            if (NUM_OUT == 1) begin
              w_state_next = ST_RUN;
              w_done_next  = 1'b1;
            end else begin
              w_state_next = ST_RELEASE;
            end
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (!Hold) begin
            if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
              w_rst_out_next = w_released;
              w_cnt_next     = '0;
              w_idx_next     = r_idx + 1'b1;
              if (r_idx == IDX_W'(NUM_OUT - 1)) begin
                w_done_next  = 1'b1;
                w_state_next = ST_RUN;
              end
            end else begin
              w_cnt_next = r_cnt + 1'b1;
            end
          end
        end
        ST_RUN: begin
          w_state_next = ST_RUN;
        end
        default: begin
          w_state_next   = ST_ASSERT;
          w_cnt_next     = '0;
          w_idx_next     = '0;
          w_rst_out_next = '0;
          w_done_next    = 1'b0;
        end
      endcase
    end
  end

  assign Soft_Rst_Ack = r_ack;
  assign Clk_En       = r_clk_en;
  assign Rst_Out      = r_rst_out;
  assign Rst_Done     = r_done;

endmodule
